// File: rtl/perceptron_feature_acc_if.sv
// rtl/perceptron_feature_acc_if.sv - feature-beat input stream and committed-count output handshake
// Parameters: EDGE_W, CURVE_W (count widths, must match the attached block).
// Signals:
//   feat_valid, feat_ready, feat_kind[1:0], sof, eof : feature beat stream into the accumulator
//   out_valid, out_ready, edges, curves               : committed frame result to the classifier
//   sat_flag                                          : present only with FEAT_ACC_SAT_FLAG_EN
// Modports: slave = accumulator view, master = feeder/consumer view.
interface perceptron_feature_acc_if #(
    parameter int EDGE_W  = 3,
    parameter int CURVE_W = 4
) ();
    logic               feat_valid;
    logic               feat_ready;
    logic [1:0]         feat_kind;
    logic               sof;
    logic               eof;
    logic               out_valid;
    logic               out_ready;
    logic [EDGE_W-1:0]  edges;
    logic [CURVE_W-1:0] curves;
`ifdef FEAT_ACC_SAT_FLAG_EN
    logic               sat_flag;
`endif

    modport slave (
`ifdef FEAT_ACC_SAT_FLAG_EN
        output sat_flag,
`endif
        input  feat_valid, feat_kind, sof, eof, out_ready,
        output feat_ready, out_valid, edges, curves
    );

    modport master (
`ifdef FEAT_ACC_SAT_FLAG_EN
        input  sat_flag,
`endif
        output feat_valid, feat_kind, sof, eof, out_ready,
        input  feat_ready, out_valid, edges, curves
    );
endinterface

// File: rtl/perceptron_feature_acc.sv
// rtl/perceptron_feature_acc.sv - per-frame saturating edge/curve hit counter feeding the perceptron classifier
// Optional feature macro: FEAT_ACC_SAT_FLAG_EN (adds bus.sat_flag, set when a frame saturated a counter).
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : perceptron_feature_acc_if.slave (feature beat stream in, committed edges/curves out)
module perceptron_feature_acc #(
    parameter int EDGE_W  = 3,
    parameter int CURVE_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    perceptron_feature_acc_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [EDGE_W-1:0]  edge_cnt;
    logic [EDGE_W-1:0]  edge_base;
    logic [EDGE_W-1:0]  edge_sum;
    logic [CURVE_W-1:0] curve_cnt;
    logic [CURVE_W-1:0] curve_base;
    logic [CURVE_W-1:0] curve_sum;
    logic [EDGE_W-1:0]  edges_q;
    logic [CURVE_W-1:0] curves_q;
    logic               out_valid_q;
    logic               feat_rdy;
    logic               accept;
    logic               active;
    logic               commit;
    logic               release_out;

    always_comb begin
        // In HOLD a beat may only enter on the same cycle the result is taken,
        // so a new frame can start back-to-back without overwriting an unread result.
        feat_rdy    = (state == HOLD) ? bus.out_ready : 1'b1;
        accept      = bus.feat_valid && feat_rdy;
        // Outside ACCUM only a sof beat opens a frame; everything else is dropped.
        active      = accept && ((state == ACCUM) || bus.sof);
        commit      = active && bus.eof;
        release_out = (state == HOLD) && bus.out_ready;

        // sof always restarts from zero, even mid-frame.
        edge_base   = bus.sof ? '0 : edge_cnt;
        curve_base  = bus.sof ? '0 : curve_cnt;
        edge_sum    = (&edge_base)  ? edge_base
                                    : edge_base  + {{(EDGE_W-1){1'b0}},  bus.feat_kind[0]};
        curve_sum   = (&curve_base) ? curve_base
                                    : curve_base + {{(CURVE_W-1){1'b0}}, bus.feat_kind[1]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (active) begin
                    state_nxt = commit ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (active) begin
                        state_nxt = commit ? HOLD : ACCUM;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt    <= '0;
            curve_cnt   <= '0;
            edges_q     <= '0;
            curves_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (commit) begin
            edge_cnt    <= '0;
            curve_cnt   <= '0;
            edges_q     <= edge_sum;
            curves_q    <= curve_sum;
            out_valid_q <= 1'b1;
        end else begin
            if (active) begin
                edge_cnt  <= edge_sum;
                curve_cnt <= curve_sum;
            end
            // edges/curves keep their last value after the handshake.
            if (release_out) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.feat_ready = feat_rdy;
    assign bus.out_valid  = out_valid_q;
    assign bus.edges      = edges_q;
    assign bus.curves     = curves_q;

`ifdef FEAT_ACC_SAT_FLAG_EN
    logic sat_run;
    logic sat_hit;
    logic sat_frame;
    logic sat_q;

    always_comb begin
        // A hit counts only when an increment is requested on an already-full counter.
        sat_hit   = ((&edge_base) && bus.feat_kind[0]) || ((&curve_base) && bus.feat_kind[1]);
        sat_frame = (bus.sof ? 1'b0 : sat_run) | sat_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_run <= 1'b0;
            sat_q   <= 1'b0;
        end else if (commit) begin
            sat_run <= 1'b0;
            sat_q   <= sat_frame;
        end else begin
            if (active) begin
                sat_run <= sat_frame;
            end
            if (release_out) begin
                sat_q <= 1'b0;
            end
        end
    end

    assign bus.sat_flag = sat_q;
`endif
endmodule

// File: tb/tb_perceptron_feature_acc.sv
// tb/tb_perceptron_feature_acc.sv - directed vector bench for perceptron_feature_acc
module tb_perceptron_feature_acc;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    perceptron_feature_acc_if #(.EDGE_W(3), .CURVE_W(4)) bus ();

    perceptron_feature_acc #(.EDGE_W(3), .CURVE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] k;
        logic       s;
        logic       e;
        logic       ordy;
        logic       x_rdy;
        logic       x_ov;
        logic [2:0] x_edges;
        logic [3:0] x_curves;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] k, input logic s, input logic e, input logic r);
        @(negedge clk);
        bus.feat_valid = v;
        bus.feat_kind  = k;
        bus.sof        = s;
        bus.eof        = e;
        bus.out_ready  = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        //             v     kind   sof   eof   ordy  rdy   ov    edges curves
        vecs[0]  = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0};
        vecs[1]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0};
        vecs[2]  = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0};
        vecs[3]  = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 4'd2};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 4'd2};
        vecs[5]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 4'd2};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 4'd2};
        vecs[7]  = '{1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 4'd1};
        vecs[8]  = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 4'd1};
        vecs[9]  = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 4'd1};
        vecs[10] = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 4'd1};
        vecs[11] = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 4'd1};
        vecs[12] = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 4'd1};
        vecs[13] = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 4'd1};
        vecs[14] = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 4'd0};
        vecs[15] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 4'd0};
        vecs[16] = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 4'd0};
        vecs[17] = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 4'd0};
        vecs[18] = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 4'd0};
        vecs[19] = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 4'd0};
        vecs[20] = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 4'd0};
        vecs[21] = '{1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 4'd1};
        vecs[22] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd1};

        rst_n          = 1'b0;
        bus.feat_valid = 1'b0;
        bus.feat_kind  = 2'b00;
        bus.sof        = 1'b0;
        bus.eof        = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid",  32'(bus.out_valid),  32'd0);
        chk("reset edges",      32'(bus.edges),      32'd0);
        chk("reset curves",     32'(bus.curves),     32'd0);
        chk("reset feat_ready", 32'(bus.feat_ready), 32'd1);
`ifdef FEAT_ACC_SAT_FLAG_EN
        chk("reset sat_flag",   32'(bus.sat_flag),   32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].v, vecs[i].k, vecs[i].s, vecs[i].e, vecs[i].ordy);
            #1;
            chk($sformatf("vec%0d feat_ready", i), 32'(bus.feat_ready), 32'(vecs[i].x_rdy));
            step();
            chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].x_ov));
            chk($sformatf("vec%0d edges", i),     32'(bus.edges),     32'(vecs[i].x_edges));
            chk($sformatf("vec%0d curves", i),    32'(bus.curves),    32'(vecs[i].x_curves));
        end

        // Saturation: 9 edge hits and 20 curve hits in one frame.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, (i < 9) ? 2'b11 : 2'b10, (i == 0), (i == 19), 1'b1);
            step();
        end
        chk("sat out_valid", 32'(bus.out_valid), 32'd1);
        chk("sat edges",     32'(bus.edges),     32'd7);
        chk("sat curves",    32'(bus.curves),    32'd15);
`ifdef FEAT_ACC_SAT_FLAG_EN
        chk("sat sat_flag",  32'(bus.sat_flag),  32'd1);
`endif
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        chk("sat ack out_valid", 32'(bus.out_valid), 32'd0);
        chk("sat ack edges",     32'(bus.edges),     32'd7);
`ifdef FEAT_ACC_SAT_FLAG_EN
        chk("sat ack sat_flag",  32'(bus.sat_flag),  32'd0);
`endif

        // Asynchronous reset during ACCUM.
        drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst accum out_valid",  32'(bus.out_valid),  32'd0);
        chk("rst accum edges",      32'(bus.edges),      32'd0);
        chk("rst accum curves",     32'(bus.curves),     32'd0);
        chk("rst accum feat_ready", 32'(bus.feat_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        // A no-sof eof beat right after reset must be dropped (block is back in IDLE).
        drive(1'b1, 2'b01, 1'b0, 1'b1, 1'b1);
        step();
        chk("post rst drop out_valid", 32'(bus.out_valid), 32'd0);
        drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
        step();
        chk("post rst out_valid", 32'(bus.out_valid), 32'd1);
        chk("post rst edges",     32'(bus.edges),     32'd2);
        chk("post rst curves",    32'(bus.curves),    32'd0);
`ifdef FEAT_ACC_SAT_FLAG_EN
        chk("post rst sat_flag",  32'(bus.sat_flag),  32'd0);
`endif

        // Asynchronous reset during HOLD (out_ready low, so feat_ready is 0 before reset).
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        #1;
        chk("hold feat_ready", 32'(bus.feat_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst hold out_valid",  32'(bus.out_valid),  32'd0);
        chk("rst hold edges",      32'(bus.edges),      32'd0);
        chk("rst hold curves",     32'(bus.curves),     32'd0);
        chk("rst hold feat_ready", 32'(bus.feat_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'b10, 1'b1, 1'b1, 1'b1);
        step();
        chk("after hold rst edges",  32'(bus.edges),  32'd0);
        chk("after hold rst curves", 32'(bus.curves), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
